// File: rtl/dram_id_remap_pkg.sv
// dram_id_remap_pkg: shared types for the DRAM AXI ID remapper.
package dram_id_remap_pkg;
    localparam int StallCntWidth = 32;
    localparam int EntryIdWidth  = 16;
    localparam int DefSlvIdWidth = 6;
    localparam int DefMstIdWidth = 4;

    typedef logic [7:0] cnt_t;

    // Stored ID is zero-extended to EntryIdWidth so any SlvIdWidth up to 16 fits.
    typedef struct packed {
        logic                    valid;
        logic [EntryIdWidth-1:0] id;
        cnt_t                    cnt;
    } entry_t;

    typedef struct packed {
        logic [DefSlvIdWidth-1:0] id;
        logic [31:0]              addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } slv_ax_t;

    typedef struct packed {
        logic [DefMstIdWidth-1:0] id;
        logic [31:0]              addr;
        logic [7:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } mst_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    typedef struct packed {
        logic [DefSlvIdWidth-1:0] id;
        logic [1:0]               resp;
    } slv_b_t;

    typedef struct packed {
        logic [DefMstIdWidth-1:0] id;
        logic [1:0]               resp;
    } mst_b_t;

    typedef struct packed {
        logic [DefSlvIdWidth-1:0] id;
        logic [31:0]              data;
        logic [1:0]               resp;
        logic                     last;
    } slv_r_t;

    typedef struct packed {
        logic [DefMstIdWidth-1:0] id;
        logic [31:0]              data;
        logic [1:0]               resp;
        logic                     last;
    } mst_r_t;

    typedef struct packed {
        slv_ax_t aw;
        logic    aw_valid;
        w_t      w;
        logic    w_valid;
        logic    b_ready;
        slv_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_slv_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        slv_b_t b;
        logic   b_valid;
        slv_r_t r;
        logic   r_valid;
    } axi_slv_rsp_t;

    typedef struct packed {
        mst_ax_t aw;
        logic    aw_valid;
        w_t      w;
        logic    w_valid;
        logic    b_ready;
        mst_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_mst_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        mst_b_t b;
        logic   b_valid;
        mst_r_t r;
        logic   r_valid;
    } axi_mst_rsp_t;
endpackage

// File: rtl/dram_id_remap_table.sv
// dram_id_remap_table: one direction's ID remap table (lookup, allocation, counts, response ID restore).
module dram_id_remap_table
    import dram_id_remap_pkg::*;
#(
    parameter int SlvIdWidth   = 6,
    parameter int MstIdWidth   = 4,
    parameter int MaxTxnsPerId = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [SlvIdWidth-1:0] req_id,
    output logic                  grant,
    output logic [MstIdWidth-1:0] slot,
    input  logic                  inc,
    input  logic                  dec,
    input  logic [MstIdWidth-1:0] rsp_slot,
    output logic [SlvIdWidth-1:0] rsp_id
);
    localparam int Slots = 2 ** MstIdWidth;

    entry_t tbl_q [Slots];
    entry_t tbl_d [Slots];
    logic hit, any_free;
    logic [MstIdWidth-1:0] hit_idx, free_idx;

    // Descending scan leaves the lowest matching/free index selected.
    always_comb begin
        hit      = 1'b0;
        any_free = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = Slots - 1; i >= 0; i--) begin
            if (tbl_q[i].valid && tbl_q[i].id == EntryIdWidth'(req_id)) begin
                hit     = 1'b1;
                hit_idx = MstIdWidth'(i);
            end
            if (!tbl_q[i].valid) begin
                any_free = 1'b1;
                free_idx = MstIdWidth'(i);
            end
        end
        slot   = hit ? hit_idx : free_idx;
        grant  = hit ? tbl_q[hit_idx].cnt < cnt_t'(MaxTxnsPerId) : any_free;
        rsp_id = tbl_q[rsp_slot].valid ? SlvIdWidth'(tbl_q[rsp_slot].id) : '0;
    end

    // A response on a free slot is ignored so the count never wraps below 0.
    always_comb begin
        tbl_d = tbl_q;
        for (int i = 0; i < Slots; i++) begin
            tbl_d[i].cnt   = tbl_q[i].cnt + cnt_t'(inc && slot == MstIdWidth'(i))
                           - cnt_t'(dec && rsp_slot == MstIdWidth'(i) && tbl_q[i].valid);
            tbl_d[i].id    = (inc && slot == MstIdWidth'(i)) ? EntryIdWidth'(req_id) : tbl_q[i].id;
            tbl_d[i].valid = tbl_d[i].cnt != '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tbl_q <= '{default: '0};
        else tbl_q <= tbl_d;
    end
endmodule

// File: rtl/dram_id_remap.sv
// dram_id_remap: folds wide SoC AXI IDs onto 2**MstIdWidth DRAM IDs, preserving same-ID ordering.
// Define DRAM_ID_REMAP_STALL_CNT_EN to count cycles in which AW or AR is held back.
module dram_id_remap
    import dram_id_remap_pkg::*;
#(
    parameter int  SlvIdWidth   = DefSlvIdWidth,
    parameter int  MstIdWidth   = DefMstIdWidth,
    parameter int  MaxTxnsPerId = 8,
    parameter type slv_req_t    = axi_slv_req_t,
    parameter type slv_rsp_t    = axi_slv_rsp_t,
    parameter type mst_req_t    = axi_mst_req_t,
    parameter type mst_rsp_t    = axi_mst_rsp_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  slv_req_t                 slv_req_i,
    output slv_rsp_t                 slv_rsp_o,
    output mst_req_t                 mst_req_o,
    input  mst_rsp_t                 mst_rsp_i,
    output logic [StallCntWidth-1:0] stall_cnt_o
);
    logic wr_grant, rd_grant, aw_hs, ar_hs, b_hs, r_hs;
    logic [MstIdWidth-1:0] wr_slot, rd_slot;
    logic [SlvIdWidth-1:0] b_id, r_id;

    assign aw_hs = slv_req_i.aw_valid & wr_grant & mst_rsp_i.aw_ready;
    assign ar_hs = slv_req_i.ar_valid & rd_grant & mst_rsp_i.ar_ready;
    assign b_hs  = mst_rsp_i.b_valid & slv_req_i.b_ready;
    assign r_hs  = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;

    dram_id_remap_table #(
        .SlvIdWidth(SlvIdWidth), .MstIdWidth(MstIdWidth), .MaxTxnsPerId(MaxTxnsPerId)
    ) u_wr (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_id(slv_req_i.aw.id), .grant(wr_grant), .slot(wr_slot),
        .inc(aw_hs), .dec(b_hs), .rsp_slot(mst_rsp_i.b.id), .rsp_id(b_id)
    );

    dram_id_remap_table #(
        .SlvIdWidth(SlvIdWidth), .MstIdWidth(MstIdWidth), .MaxTxnsPerId(MaxTxnsPerId)
    ) u_rd (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_id(slv_req_i.ar.id), .grant(rd_grant), .slot(rd_slot),
        .inc(ar_hs), .dec(r_hs), .rsp_slot(mst_rsp_i.r.id), .rsp_id(r_id)
    );

    // Valids are gated by rst_ni so nothing leaks out while reset is held.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw.id    = wr_slot;
        mst_req_o.aw.addr  = slv_req_i.aw.addr;
        mst_req_o.aw.len   = slv_req_i.aw.len;
        mst_req_o.aw.size  = slv_req_i.aw.size;
        mst_req_o.aw.burst = slv_req_i.aw.burst;
        mst_req_o.aw_valid = rst_ni & slv_req_i.aw_valid & wr_grant;
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        mst_req_o.ar.id    = rd_slot;
        mst_req_o.ar.addr  = slv_req_i.ar.addr;
        mst_req_o.ar.len   = slv_req_i.ar.len;
        mst_req_o.ar.size  = slv_req_i.ar.size;
        mst_req_o.ar.burst = slv_req_i.ar.burst;
        mst_req_o.ar_valid = rst_ni & slv_req_i.ar_valid & rd_grant;
        mst_req_o.r_ready  = slv_req_i.r_ready;
    end

    always_comb begin
        slv_rsp_o          = '0;
        slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & wr_grant;
        slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & rd_grant;
        slv_rsp_o.w_ready  = mst_rsp_i.w_ready;
        slv_rsp_o.b.id     = b_id;
        slv_rsp_o.b.resp   = mst_rsp_i.b.resp;
        slv_rsp_o.b_valid  = rst_ni & mst_rsp_i.b_valid;
        slv_rsp_o.r.id     = r_id;
        slv_rsp_o.r.data   = mst_rsp_i.r.data;
        slv_rsp_o.r.resp   = mst_rsp_i.r.resp;
        slv_rsp_o.r.last   = mst_rsp_i.r.last;
        slv_rsp_o.r_valid  = rst_ni & mst_rsp_i.r_valid;
    end

`ifdef DRAM_ID_REMAP_STALL_CNT_EN
    logic [StallCntWidth-1:0] stall_q;
    logic stall;

    assign stall = (slv_req_i.aw_valid & ~wr_grant) | (slv_req_i.ar_valid & ~rd_grant);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_q <= '0;
        else stall_q <= stall_q + StallCntWidth'(stall && !(&stall_q));
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif
endmodule

// File: doc/dram_id_remap.md
DRAM_ID_REMAP -- requirements
Module: dram_id_remap

Interface
REQ-001 SHALL have parameter SlvIdWidth, default 6: AXI ID width on the SoC-side slave port.
REQ-002 SHALL have parameter MstIdWidth, default 4: AXI ID width toward DRAM; Slots = 2**MstIdWidth; MstIdWidth < SlvIdWidth.
REQ-003 SHALL have parameter MaxTxnsPerId, default 8: maximum outstanding transactions per slot, range 1..255.
REQ-004 SHALL have type parameters slv_req_t, slv_rsp_t, mst_req_t and mst_rsp_t, default logic: AXI structs that differ only in ID width.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port slv_req_i, input, slv_req_t: request from the SoC or axi_cut.
REQ-008 SHALL have port slv_rsp_o, output, slv_rsp_t: response to the SoC.
REQ-009 SHALL have port mst_req_o, output, mst_req_t: request to the memory controller.
REQ-010 SHALL have port mst_rsp_i, input, mst_rsp_t: response from the memory controller.
REQ-011 SHALL have port stall_cnt_o, output, 32 bits: count of cycles in which an AW or AR was blocked by the remapper.

Function
REQ-012 SHALL implement two independent remap tables, one for writes (AW/B) and one for reads (AR/R); each entry holds a valid bit, an original SlvIdWidth ID and an 8-bit outstanding count.
REQ-013 SHALL, for an incoming AW or AR with ID X, grant the slot whose stored ID equals X when its count < MaxTxnsPerId.
REQ-014 SHALL, when no slot stores X, grant the lowest-index free slot (count == 0).
REQ-015 SHALL NOT grant any slot when X is stored but its count == MaxTxnsPerId, or when X is not stored and no slot is free; this keeps same-ID ordering intact.
REQ-016 SHALL drive mst aw_valid = slv aw_valid & grant and slv aw_ready = mst aw_ready & grant; AR SHALL behave identically.
REQ-017 SHALL forward all other AW/AR fields unchanged, with the ID replaced by the slot index; latency is 0 cycles and the path is combinational.
REQ-018 SHALL pass the W channel through untouched.
REQ-019 SHALL drive slv b.id = table_wr[mst b.id].id and slv r.id = table_rd[mst r.id].id; all other response fields and handshakes pass through.
REQ-020 SHALL increment a slot's count on an AW/AR handshake at the master side.
REQ-021 SHALL decrement a slot's count on a B handshake, or on an R handshake with last = 1.
REQ-022 SHALL leave the count unchanged when increment and decrement hit the same slot in the same cycle.
REQ-023 SHALL make a slot free when its count reaches 0; the stored ID is don't-care and may be reallocated in the next cycle.
REQ-024 SHALL treat a response on a free slot as a protocol error: the count saturates at 0, and the response is still forwarded with ID 0.
REQ-025 SHALL keep a valid request with no grant stalled; it SHALL NOT be dropped, and its fields SHALL remain stable per AXI.

Reset
REQ-026 SHALL, while rst_ni = 0, clear all counts and IDs to 0 and drive stall_cnt_o = 0, mst aw_valid/ar_valid = 0 and slv b_valid/r_valid = 0.
REQ-027 SHALL NOT complete a transaction that was in flight when reset asserted mid-operation; the memory controller side SHALL be reset in the same domain.

Configuration
REQ-028 SHALL use macro DRAM_ID_REMAP_STALL_CNT_EN.
REQ-029 SHALL, when DRAM_ID_REMAP_STALL_CNT_EN is defined, add 1 to stall_cnt_o each cycle in which (aw_valid & !grant_aw) | (ar_valid & !grant_ar); the counter saturates at 0xFFFFFFFF.
REQ-030 SHALL, when DRAM_ID_REMAP_STALL_CNT_EN is not defined, tie stall_cnt_o to 0 and infer no counter logic.

Structure
REQ-031 SHALL place in package dram_id_remap_pkg: cnt_t (8 bits), the stall counter width constant (32), and the table entry struct typedef parameterized via a localparam width.
REQ-032 SHALL use sub-module dram_id_remap_table, instantiated twice (write and read); it holds lookup, allocation, count update and response ID restore.

Verification
REQ-033 SHALL cover: AW id=0x2A, then AW id=0x15 -> mst ids 0 and 1; B with id 1 -> slv b.id = 0x15, slot 1 freed.
REQ-034 SHALL cover: 9 ARs with id=0x3 and MaxTxnsPerId=8 -> first 8 pass on slot 0, the 9th stalls; after one R with last=1 it issues the next cycle on slot 0.
REQ-035 SHALL cover: 16 distinct AW IDs outstanding and a 17th distinct ID -> aw_ready = 0 until any B returns; the 17th then takes the freed slot index.
REQ-036 SHALL cover: an AR handshake and an R-last on the same slot in the same cycle -> count unchanged, slot stays allocated.
REQ-037 SHALL cover: rst_ni pulsed low with 5 reads outstanding -> all slots free, stall_cnt_o = 0, and a fresh AR id=0x3F maps to slot 0.
REQ-038 SHALL cover, with DRAM_ID_REMAP_STALL_CNT_EN defined: AW held blocked 10 cycles -> stall_cnt_o = 10; without the macro -> stall_cnt_o stays 0.
